// File: rtl/nbit_countdown_timer.sv
// Loadable N-bit down-counter with start/pause/abort, clock prescaler,
// one-cycle done pulse, sticky expired flag and optional auto-reload.
module nbit_countdown_timer #(
  parameter int N           = 10,
  parameter int PRESCALE    = 1,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         abort,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic         start,
  input  logic         pause,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         done,
  output logic         expired
);

  localparam int              PW            = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRESCALE_LAST = PW'(PRESCALE - 1);
  localparam logic [N-1:0]    ONE           = N'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [N-1:0]  reload_reg, reload_next;
  logic [N-1:0]  count_next;
  logic [PW-1:0] prescaler, prescaler_next;
  logic          done_next;
  logic          expired_next;
  logic          busy_next;
  logic          tick;
  logic [N-1:0]  start_value;

  // A load in the same cycle as start supplies the starting value directly.
  assign start_value = load ? load_value : count;
  assign tick        = (prescaler == PRESCALE_LAST);
  assign busy_next   = (state_next == RUN) || (state_next == PAUSED);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      prescaler  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      expired    <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      reload_reg <= reload_next;
      prescaler  <= prescaler_next;
      busy       <= busy_next;
      done       <= done_next;
      expired    <= expired_next;
    end
  end

  always_comb begin
    state_next     = state;
    count_next     = count;
    reload_next    = reload_reg;
    prescaler_next = prescaler;
    done_next      = 1'b0;
    expired_next   = expired;

    if (abort) begin
      state_next     = IDLE;
      count_next     = '0;
      prescaler_next = '0;
      expired_next   = 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (load) begin
            count_next   = load_value;
            reload_next  = load_value;
            expired_next = 1'b0;
            state_next   = IDLE;
          end
          if (start) begin
            if (start_value != '0) begin
              state_next     = RUN;
              prescaler_next = '0;
            end else begin
              state_next   = DONE;
              done_next    = 1'b1;
              expired_next = 1'b1;
            end
          end
        end

        RUN: begin
          // Pause freezes the prescaler and swallows the tick of this cycle.
          if (pause) begin
            state_next = PAUSED;
          end else if (tick) begin
            prescaler_next = '0;
            if (count <= ONE) begin
              done_next    = 1'b1;
              expired_next = 1'b1;
              if (AUTO_RELOAD && (reload_reg != '0)) begin
                count_next = reload_reg;
              end else begin
                count_next = '0;
                state_next = DONE;
              end
            end else begin
              count_next = count - ONE;
            end
          end else begin
            prescaler_next = prescaler + 1'b1;
          end
        end

        PAUSED: begin
          if (start) state_next = RUN;
        end

        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nbit_countdown_timer.sv
// Table-driven, scoreboarded bench for nbit_countdown_timer covering
// PRESCALE=1, PRESCALE=4 and AUTO_RELOAD=1 instances driven in parallel.
module tb_nbit_countdown_timer;

  localparam int N = 10;

  typedef struct {
    logic         rst;
    logic         abrt;
    logic         ld;
    logic [N-1:0] lv;
    logic         st;
    logic         ps;
    logic [N-1:0] e_count;
    logic         e_busy;
    logic         e_done;
    logic         e_exp;
    string        name;
  } vec_t;

  typedef struct {
    int           sel;
    logic [N-1:0] count;
    logic         busy;
    logic         done;
    logic         expired;
    string        name;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         abort = 1'b0;
  logic         load = 1'b0;
  logic [N-1:0] load_value = '0;
  logic         start = 1'b0;
  logic         pause = 1'b0;

  logic [N-1:0] count_p1, count_p4, count_ar;
  logic         busy_p1, busy_p4, busy_ar;
  logic         done_p1, done_p4, done_ar;
  logic         expired_p1, expired_p4, expired_ar;

  int n_compared = 0;
  int n_mismatched = 0;

  exp_t exp_q[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  nbit_countdown_timer #(.N(N), .PRESCALE(1), .AUTO_RELOAD(1'b0)) dut_p1 (
    .clk(clk), .reset(reset), .abort(abort), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .count(count_p1), .busy(busy_p1), .done(done_p1),
    .expired(expired_p1)
  );

  nbit_countdown_timer #(.N(N), .PRESCALE(4), .AUTO_RELOAD(1'b0)) dut_p4 (
    .clk(clk), .reset(reset), .abort(abort), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .count(count_p4), .busy(busy_p4), .done(done_p4),
    .expired(expired_p4)
  );

  nbit_countdown_timer #(.N(N), .PRESCALE(1), .AUTO_RELOAD(1'b1)) dut_ar (
    .clk(clk), .reset(reset), .abort(abort), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .count(count_ar), .busy(busy_ar), .done(done_ar),
    .expired(expired_ar)
  );

  function automatic vec_t mkv(input logic rst, input logic abrt, input logic ld,
                               input int lv, input logic st, input logic ps,
                               input int ec, input logic eb, input logic ed,
                               input logic ex, input string nm);
    vec_t v;
    v.rst = rst; v.abrt = abrt; v.ld = ld; v.lv = N'(lv); v.st = st; v.ps = ps;
    v.e_count = N'(ec); v.e_busy = eb; v.e_done = ed; v.e_exp = ex; v.name = nm;
    return v;
  endfunction

  task automatic checkOutput();
    exp_t         e;
    logic [N-1:0] c;
    logic         b, d, x;
    n_compared++;
    if (exp_q.size() == 0) begin
      n_mismatched++;
      $display("[TB] FAIL scoreboard_empty: got no expectation, required one");
      return;
    end
    e = exp_q.pop_front();
    case (e.sel)
      0:       begin c = count_p1; b = busy_p1; d = done_p1; x = expired_p1; end
      1:       begin c = count_p4; b = busy_p4; d = done_p4; x = expired_p4; end
      default: begin c = count_ar; b = busy_ar; d = done_ar; x = expired_ar; end
    endcase
    if (c !== e.count || b !== e.busy || d !== e.done || x !== e.expired) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got count=%0d busy=%b done=%b expired=%b, required count=%0d busy=%b done=%b expired=%b",
               e.name, c, b, d, x, e.count, e.busy, e.done, e.expired);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int sel);
    exp_t e;
    reset      = v.rst;
    abort      = v.abrt;
    load       = v.ld;
    load_value = v.lv;
    start      = v.st;
    pause      = v.ps;
    e.sel = sel; e.count = v.e_count; e.busy = v.e_busy;
    e.done = v.e_done; e.expired = v.e_exp; e.name = v.name;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, required normal completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // rst abrt ld lv st ps | count busy done expired
    vecs.push_back(mkv(1,0,0,0,0,0, 0,0,0,0, "t01_reset"));
    vecs.push_back(mkv(0,0,1,5,0,0, 5,0,0,0, "t02_load5"));
    vecs.push_back(mkv(0,0,0,0,1,0, 5,1,0,0, "t03_start"));
    vecs.push_back(mkv(0,0,0,0,0,0, 4,1,0,0, "t04_cnt4"));
    vecs.push_back(mkv(0,0,0,0,0,0, 3,1,0,0, "t05_cnt3"));
    vecs.push_back(mkv(0,0,0,0,0,0, 2,1,0,0, "t06_cnt2"));
    vecs.push_back(mkv(0,0,0,0,0,0, 1,1,0,0, "t07_cnt1"));
    vecs.push_back(mkv(0,0,0,0,0,0, 0,0,1,1, "t08_expire"));
    vecs.push_back(mkv(0,0,0,0,0,0, 0,0,0,1, "t09_done_drop"));
    vecs.push_back(mkv(0,0,0,0,1,0, 0,0,1,1, "t10_start_zero_in_done"));
    vecs.push_back(mkv(0,0,0,0,0,0, 0,0,0,1, "t11_single_pulse"));
    vecs.push_back(mkv(0,0,1,0,0,0, 0,0,0,0, "t12_load0_clears_exp"));
    vecs.push_back(mkv(0,0,0,0,1,0, 0,0,1,1, "t13_start_zero"));
    vecs.push_back(mkv(0,0,0,0,0,0, 0,0,0,1, "t14_zero_done_drop"));
    vecs.push_back(mkv(0,1,0,0,0,0, 0,0,0,0, "t15_abort_idle"));
    vecs.push_back(mkv(0,0,1,3,1,0, 3,1,0,0, "t16_load_start3"));
    vecs.push_back(mkv(0,0,1,6,0,0, 2,1,0,0, "t17_load_in_run_ignored"));
    vecs.push_back(mkv(0,0,0,0,0,1, 2,1,0,0, "t18_pause"));
    vecs.push_back(mkv(0,0,1,6,0,1, 2,1,0,0, "t19_paused_hold"));
    vecs.push_back(mkv(0,0,0,0,1,0, 2,1,0,0, "t20_resume"));
    vecs.push_back(mkv(0,0,0,0,0,0, 1,1,0,0, "t21_cnt1"));
    vecs.push_back(mkv(0,0,0,0,0,0, 0,0,1,1, "t22_expire"));
    vecs.push_back(mkv(0,0,1,5,1,0, 5,1,0,0, "t23_reload_start5"));
    vecs.push_back(mkv(0,0,0,0,0,0, 4,1,0,0, "t24_cnt4"));
    vecs.push_back(mkv(0,0,0,0,0,0, 3,1,0,0, "t25_cnt3"));
    vecs.push_back(mkv(1,0,0,0,0,0, 0,0,0,0, "t26_reset_mid_run"));
    vecs.push_back(mkv(0,0,0,0,1,0, 0,0,1,1, "t27_start_after_reset"));
    vecs.push_back(mkv(0,0,0,0,0,0, 0,0,0,1, "t28_done_drop"));
    vecs.push_back(mkv(0,0,1,4,1,0, 4,1,0,0, "t29_load_start4"));
    vecs.push_back(mkv(0,0,0,0,0,0, 3,1,0,0, "t30_cnt3"));
    vecs.push_back(mkv(0,1,0,0,0,0, 0,0,0,0, "t31_abort_mid_run"));
    vecs.push_back(mkv(0,0,0,0,0,0, 0,0,0,0, "t32_idle_hold"));

    @(negedge clk);
    foreach (vecs[i]) applyStimulus(vecs[i], 0);

    // Pause after 3 ticks for 5 cycles: done lands 15 edges after start.
    applyStimulus(mkv(1,0,0,0,0,0, 0,0,0,0, "p_reset"), 0);
    applyStimulus(mkv(0,0,1,10,0,0, 10,0,0,0, "p_load10"), 0);
    applyStimulus(mkv(0,0,0,0,1,0, 10,1,0,0, "p_start"), 0);
    for (int k = 9; k >= 7; k--)
      applyStimulus(mkv(0,0,0,0,0,0, k,1,0,0, "p_tick"), 0);
    applyStimulus(mkv(0,0,0,0,0,1, 7,1,0,0, "p_pause"), 0);
    for (int k = 0; k < 3; k++)
      applyStimulus(mkv(0,0,0,0,0,0, 7,1,0,0, "p_frozen"), 0);
    applyStimulus(mkv(0,0,0,0,1,0, 7,1,0,0, "p_resume"), 0);
    for (int k = 6; k >= 1; k--)
      applyStimulus(mkv(0,0,0,0,0,0, k,1,0,0, "p_after_resume"), 0);
    applyStimulus(mkv(0,0,0,0,0,0, 0,0,1,1, "p_expire"), 0);

    // PRESCALE=4: each value held 4 cycles, done 12 edges after start.
    applyStimulus(mkv(1,0,0,0,0,0, 0,0,0,0, "s4_reset"), 1);
    applyStimulus(mkv(0,0,1,3,1,0, 3,1,0,0, "s4_load_start3"), 1);
    for (int k = 1; k <= 12; k++)
      applyStimulus(mkv(0,0,0,0,0,0, 3 - k / 4, (k < 12), (k == 12), (k == 12), "s4_prescaled"), 1);
    applyStimulus(mkv(0,0,0,0,0,0, 0,0,0,1, "s4_done_drop"), 1);

    // AUTO_RELOAD: count 2,1,(2 with done),1,(2 with done)... busy stays high.
    applyStimulus(mkv(1,0,0,0,0,0, 0,0,0,0, "ar_reset"), 2);
    applyStimulus(mkv(0,0,1,2,0,0, 2,0,0,0, "ar_load2"), 2);
    applyStimulus(mkv(0,0,0,0,1,0, 2,1,0,0, "ar_start"), 2);
    for (int p = 0; p < 3; p++) begin
      applyStimulus(mkv(0,0,0,0,0,0, 1,1,0,(p > 0), "ar_cnt1"), 2);
      applyStimulus(mkv(0,0,0,0,0,0, 2,1,1,1, "ar_reload"), 2);
    end
    applyStimulus(mkv(0,1,0,0,0,0, 0,0,0,0, "ar_abort"), 2);
    applyStimulus(mkv(0,0,1,1,1,0, 1,1,0,0, "ar_load_start1"), 2);
    for (int k = 0; k < 3; k++)
      applyStimulus(mkv(0,0,0,0,0,0, 1,1,1,1, "ar_done_every_cycle"), 2);
    applyStimulus(mkv(0,1,0,0,0,0, 0,0,0,0, "ar_abort2"), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
